// File: rtl/flood_reveal_ctrl.sv
// Flood-fill reveal controller for an 8x8 tile grid: BFS over zero-adjacency tiles
// using a FIFO of tile indices and a per-operation visited bitmap.
module flood_reveal_ctrl #(
  parameter int GRID_SIZE = 8,
  parameter int QDEPTH    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   start_index,
  input  logic [63:0]  mine_map,
  input  logic [255:0] adj,
  input  logic [63:0]  revealed,
  input  logic [63:0]  flagged,
  output logic         reveal_req,
  output logic [5:0]   reveal_index,
  output logic         busy,
  output logic         done,
  output logic         hit_mine,
  output logic [6:0]   fill_count
);

  localparam int NTILES = GRID_SIZE * GRID_SIZE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    REVEAL = 3'd2,
    SCAN   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          cur_q, cur_d;
  logic [2:0]          dir_q, dir_d;
  logic [NTILES-1:0]   visited_q, visited_d;
  logic [5:0]          rd_ptr_q, rd_ptr_d;
  logic [5:0]          wr_ptr_q, wr_ptr_d;
  logic [6:0]          count_q, count_d;
  logic [6:0]          fill_count_q, fill_count_d;
  logic                hit_mine_q, hit_mine_d;
  logic                reveal_req_q, reveal_req_d;
  logic [5:0]          reveal_index_q, reveal_index_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [5:0]          q_mem_q [QDEPTH];
  logic                push_en_s;
  logic [5:0]          push_addr_s;
  logic [5:0]          push_idx_s;

  logic [3:0]          dx_s, dy_s, nx_s, ny_s;
  logic [5:0]          nidx_s;
  logic                in_grid_s;
  logic [3:0]          cur_adj_s;

  // Neighbour of cur in direction dir; offsets are 4-bit two's complement so
  // any step off the grid (to -1 or 8) lands with bit 3 set.
  always_comb begin
    case (dir_q)
      3'd0:    begin dx_s = 4'hF; dy_s = 4'hF; end
      3'd1:    begin dx_s = 4'h0; dy_s = 4'hF; end
      3'd2:    begin dx_s = 4'h1; dy_s = 4'hF; end
      3'd3:    begin dx_s = 4'hF; dy_s = 4'h0; end
      3'd4:    begin dx_s = 4'h1; dy_s = 4'h0; end
      3'd5:    begin dx_s = 4'hF; dy_s = 4'h1; end
      3'd6:    begin dx_s = 4'h0; dy_s = 4'h1; end
      3'd7:    begin dx_s = 4'h1; dy_s = 4'h1; end
      default: begin dx_s = 4'h0; dy_s = 4'h0; end
    endcase
    nx_s      = {1'b0, cur_q[2:0]} + dx_s;
    ny_s      = {1'b0, cur_q[5:3]} + dy_s;
    nidx_s    = {ny_s[2:0], nx_s[2:0]};
    in_grid_s = ~nx_s[3] & ~ny_s[3];
    cur_adj_s = adj[{cur_q, 2'b00} +: 4];
  end

  // Next-state, queue and bookkeeping logic.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    dir_d        = dir_q;
    visited_d    = visited_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fill_count_d = fill_count_q;
    hit_mine_d   = hit_mine_q;
    push_en_s    = 1'b0;
    push_addr_s  = wr_ptr_q;
    push_idx_s   = nidx_s;

    case (state_q)
      IDLE: begin
        if (start && !flagged[start_index] && !revealed[start_index]) begin
          visited_d              = '0;
          visited_d[start_index] = 1'b1;
          fill_count_d           = 7'd0;
          push_en_s              = 1'b1;
          push_addr_s            = 6'd0;
          push_idx_s             = start_index;
          rd_ptr_d               = 6'd0;
          wr_ptr_d               = 6'd1;
          count_d                = 7'd1;
          state_d                = POP;
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        if (count_q == 7'd0) begin
          state_d = DONE;
        end else begin
          cur_d    = q_mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + 6'd1;
          count_d  = count_q - 7'd1;
          state_d  = REVEAL;
        end
      end
      REVEAL: begin
        fill_count_d = fill_count_q + 7'd1;
        if (mine_map[cur_q]) begin
          hit_mine_d = 1'b1;
          rd_ptr_d   = wr_ptr_q;
          count_d    = 7'd0;
          state_d    = DONE;
        end else if (cur_adj_s == 4'd0) begin
          dir_d   = 3'd0;
          state_d = SCAN;
        end else begin
          state_d = POP;
        end
      end
      SCAN: begin
        if (in_grid_s && !visited_q[nidx_s] && !revealed[nidx_s] &&
            !flagged[nidx_s] && !mine_map[nidx_s]) begin
          push_en_s         = 1'b1;
          visited_d[nidx_s] = 1'b1;
          wr_ptr_d          = wr_ptr_q + 6'd1;
          count_d           = count_q + 7'd1;
        end else begin
          push_en_s = 1'b0;
        end
        if (dir_q == 3'd7) begin
          state_d = POP;
        end else begin
          dir_d = dir_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    reveal_req_d   = (state_d == REVEAL);
    reveal_index_d = (state_d == REVEAL) ? cur_d : reveal_index_q;
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_q          <= 6'd0;
      dir_q          <= 3'd0;
      visited_q      <= '0;
      rd_ptr_q       <= 6'd0;
      wr_ptr_q       <= 6'd0;
      count_q        <= 7'd0;
      fill_count_q   <= 7'd0;
      hit_mine_q     <= 1'b0;
      reveal_req_q   <= 1'b0;
      reveal_index_q <= 6'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      dir_q          <= dir_d;
      visited_q      <= visited_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      fill_count_q   <= fill_count_d;
      hit_mine_q     <= hit_mine_d;
      reveal_req_q   <= reveal_req_d;
      reveal_index_q <= reveal_index_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Queue storage; emptiness is tracked by count, so contents need no reset.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      q_mem_q[push_addr_s] <= push_idx_s;
    end
  end

  assign reveal_req   = reveal_req_q;
  assign reveal_index = reveal_index_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign hit_mine     = hit_mine_q;
  assign fill_count   = fill_count_q;

endmodule

// File: doc/flood_reveal_ctrl.md
FLOOD_REVEAL_CTRL -- requirements
Module: flood_reveal_ctrl

Interface
REQ-001 Parameter GRID_SIZE, default 8, tiles per row/column; only 8 is supported (64 tiles, index = y*8 + x).
REQ-002 Parameter QDEPTH, default 64, reveal queue depth in entries.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to reveal tile start_index with flood fill.
REQ-006 start_index  input  6  tile index of the cursor tile.
REQ-007 mine_map  input  64  bit i = 1 when tile i holds a mine.
REQ-008 adj  input  256  adjacent-mine count of tile i in bits [4i+3:4i].
REQ-009 revealed  input  64  current reveal state from tile storage.
REQ-010 flagged  input  64  current flag state from tile storage.
REQ-011 reveal_req  output  1  one-cycle pulse; tile storage reveals reveal_index.
REQ-012 reveal_index  output  6  index qualified by reveal_req.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 done  output  1  one-cycle pulse at the end of every accepted operation.
REQ-015 hit_mine  output  1  sticky; set when a mine tile is revealed.
REQ-016 fill_count  output  7  number of reveal_req pulses in the current/last operation.

Function
REQ-017 FSM states: IDLE, POP, REVEAL, SCAN, DONE; busy = (state != IDLE).
REQ-018 IDLE: start accepted only if tile start_index is neither flagged nor revealed; accepted start clears visited[63:0] and fill_count, pushes start_index, sets its visited bit, goes to POP.
REQ-019 start in IDLE on a flagged or revealed tile is ignored: no busy, no reveal_req, no done.
REQ-020 start while busy is ignored; the operation in progress is unaffected.
REQ-021 POP: queue empty -> DONE; otherwise dequeue head into cur and go to REVEAL.
REQ-022 REVEAL: reveal_req = 1, reveal_index = cur for exactly this cycle; fill_count increments.
REQ-023 REVEAL exit: mine_map[cur] = 1 -> set hit_mine, flush queue, go to DONE; adj[cur] = 0 -> SCAN with dir = 0; otherwise -> POP.
REQ-024 SCAN: one neighbour per cycle, dir 0..7 = NW, N, NE, W, E, SW, S, SE; out-of-grid neighbours skipped but still consume the cycle (no row wrap: x = 0 has no W side, x = 7 has no E side).
REQ-025 SCAN push condition: in-grid AND visited = 0 AND revealed = 0 AND flagged = 0 AND mine_map = 0; a push sets the visited bit the same cycle.
REQ-026 SCAN exit: after dir = 7 go to POP.
REQ-027 Queue: FIFO, 6-bit read/write pointers wrapping mod 64; visited bitmap guarantees at most 64 pushes per operation, so overflow is impossible; no push is ever dropped.
REQ-028 DONE: done = 1 for one cycle, then IDLE.
REQ-029 Accepted start at cycle t with no neighbours scanned: busy t+1..t+4, reveal_req at t+2, done at t+4, IDLE at t+5.
REQ-030 reveal_index holds its last value between pulses; each index is revealed at most once per operation.
REQ-031 hit_mine stays set across operations until rst.

Reset
REQ-032 rst = 1 at a clock edge: state IDLE, queue empty, pointers 0, visited 0; reveal_req 0, reveal_index 0, busy 0, done 0, hit_mine 0, fill_count 0.
REQ-033 rst mid-operation aborts immediately; no further reveal_req and no done pulse for the aborted operation.

Verification
REQ-034 Mine at 27, start_index 27 -> single reveal_req idx 27, hit_mine = 1, done, fill_count = 1.
REQ-035 adj[10] = 3, no mines, start idx 10 at t -> reveal_req idx 10 at t+2, done at t+4, fill_count = 1.
REQ-036 All adj = 0, no mines/flags, start idx 0 -> 64 reveal_req, every index once, order begins 0,1,8,9; fill_count = 64.
REQ-037 Column x = 3 fully flagged, all adj = 0, start idx 0 -> exactly 24 reveals, all with x < 3; no flagged tile revealed.
REQ-038 rst pulsed during SCAN of REQ-036 -> next cycle all outputs 0; a fresh start idx 63 then completes normally.
REQ-039 start on flagged tile, and start while busy -> no response / no disturbance to the running fill.
